sram_read_arbiter: RTL and testbench
====================================

# sram_read_arbiter

Two-requester read arbiter and sequencer for the board's external 16-bit asynchronous SRAM. It sits between the SRAM pins and the CNN datapath and lets two readers share the single SRAM port: port 0 is the NN feature/weight fetch, port 1 is a secondary reader such as a prefetcher or debug dump. Each read is a fixed-length access of `WAIT_CYCLES` cycles. The captured word is returned with a one-cycle valid pulse to the requester that won.

## Interface
- `WAIT_CYCLES`, default 2: cycles the address is held before `Data` is sampled; legal range 1..15.
- `CLK` input 1: single clock, 50 MHz; all state updates on the rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `req` input 2: per-port read request; bit i is port i.
- `addr0` input 20: port 0 word address.
- `addr1` input 20: port 1 word address.
- `gnt` output 2: one-cycle pulse; the port's request has been accepted and its address latched.
- `rvalid` output 2: one-cycle pulse; `rdata` holds that port's word.
- `rdata` output 16: captured read word, shared by both ports.
- `busy` output 1: high while an access is in flight.
- `ADDR` output 20: SRAM address, registered.
- `CE`, `OE` output 1: active-low chip enable and output enable.
- `WE` output 1: active-low write enable; tied high, so the block never writes.
- `UB`, `LB` output 1: active-low byte enables; tied low.
- `Data` input 16: SRAM data bus, read only.

## Operation
- State machine with two states:
  - IDLE: `busy`=0, `CE`=`OE`=1.
  - ACCESS: `busy`=1, `CE`=`OE`=0, `ADDR` stable.
- IDLE, at a rising edge with `req`≠0:
  - Pick a winner `w`.
  - `ADDR`←`addr_w`; record `w` as owner.
  - Wait counter←`WAIT_CYCLES`-1; go to ACCESS.
  - `gnt[w]`=1 for the following cycle.
- ACCESS, counter>0: decrement the counter each edge.
- ACCESS, counter=0 (the capture edge):
  - `rdata`←`Data`; `rvalid[owner]`=1 for the following cycle.
  - Sample `req` at this same edge. If it is nonzero, arbitrate and re-enter ACCESS with a new `ADDR`, `gnt` and counter. Otherwise go to IDLE.
  - There is no idle bubble between back-to-back reads.
- Requester rules:
  - Hold `req` high with a stable address until `gnt` is seen.
  - In the `gnt` cycle, the requester may drop `req` or present its next address.
  - Between acceptance and the capture edge, the arbiter ignores `req` and both address inputs.
- `rdata` holds its value until the next capture; it is not cleared when `rvalid` drops.
- A winner is chosen only from ports whose `req` bit is high. The tie-break rule is set under Configuration.

## Timing
- Reset values, applied asynchronously:
  - State IDLE, `ADDR`=0, `rdata`=0.
  - `gnt`=0, `rvalid`=0, `busy`=0.
  - `CE`=1, `OE`=1, `WE`=1, `UB`=0, `LB`=0.
  - Round-robin pointer set so that port 0 wins the first tie.
- Latency, with acceptance edge E:
  - `gnt` is high in the cycle after E.
  - The capture edge is E+`WAIT_CYCLES`.
  - `rvalid` is high in the cycle after the capture edge, i.e. `WAIT_CYCLES`+1 cycles after E.
- Throughput: one word per `WAIT_CYCLES` cycles when requests are continuously pending.
- `gnt` and `rvalid` are each at most one-hot. They can be high in the same cycle for different ports, or for the same port during back-to-back reads.
- `RESET` asserted mid-access: the access is abandoned, no `rvalid` is issued, and the owner must re-request.
- Requests for the same address from both ports are served as two separate accesses.

## Configuration
- `SRAM_ARB_RR_EN` defined (round robin):
  - When both ports request, the port not served most recently wins.
  - The pointer updates on every grant.
  - No port can be starved.
- `SRAM_ARB_RR_EN` undefined (fixed priority):
  - Port 0 always wins ties.
  - Port 1 is served only at edges where `req[0]`=0.
  - The pointer logic is omitted.

## Test plan
- Single read: `WAIT_CYCLES`=2, port 0 requests address 0x00188 while the model drives `Data`=0xBEEF → `gnt`=01 one cycle after acceptance, `CE`/`OE` low for 2 cycles, `rvalid`=01 with `rdata`=0xBEEF 3 cycles after acceptance.
- Contention with `SRAM_ARB_RR_EN`: both ports hold `req`=11 for 4 grants → grant order 0,1,0,1, `rvalid` every 2 cycles, no idle cycle between accesses.
- Contention without the macro: `req`=11 held for 4 grants → port 0 granted all 4, `gnt[1]` never asserted; then drop `req[0]` → port 1 granted at the next capture edge.
- Back-to-back pipelining: port 1 presents addresses 0,1,2 by updating `addr1` in each `gnt` cycle, with memory holding 0x1111/0x2222/0x3333 → three `rvalid[1]` pulses 2 cycles apart carrying those words in order.
- Reset mid-access: assert `RESET` one cycle after `gnt` → all outputs take their reset values immediately, no `rvalid`; after release a new request completes normally.
- Long wait: `WAIT_CYCLES`=15 → `Data` sampled exactly 15 edges after acceptance; a `Data` change at edge 14 must not appear in `rdata`.

Source files
------------

// File: rtl/sram_read_arbiter.sv
// sram_read_arbiter
//   Two-port read arbiter/sequencer for the external 16-bit asynchronous SRAM.
//   Port 0 is the NN feature/weight fetch and port 1 is a secondary reader.
//   Each read holds ADDR for WAIT_CYCLES cycles, then captures Data into rdata
//   and pulses rvalid for the port that owned the access. A new request can be
//   accepted at the capture edge, so back-to-back reads have no idle bubble.
//
// Build option:
//   SRAM_ARB_RR_EN  defined   -> round-robin tie-break (last-served port loses)
//                   undefined -> fixed priority, port 0 wins ties
//
// Parameters:
//   WAIT_CYCLES  cycles ADDR is held before Data is sampled (1..15)
//
// Ports:
//   CLK, RESET   clock; asynchronous active-high reset
//   req[1:0]     per-port read request
//   addr0/addr1  per-port 20-bit word address
//   gnt[1:0]     one-cycle pulse: request accepted, address latched
//   rvalid[1:0]  one-cycle pulse: rdata holds that port's word
//   rdata        captured read word (held until the next capture)
//   busy         access in flight
//   ADDR         registered SRAM address
//   CE, OE       active-low chip/output enable (low during an access)
//   WE           active-low write enable, tied high
//   UB, LB       active-low byte enables, tied low
//   Data         SRAM data bus (read only)
module sram_read_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [1:0]  req,
  input  logic [19:0] addr0,
  input  logic [19:0] addr1,
  output logic [1:0]  gnt,
  output logic [1:0]  rvalid,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [19:0] ADDR,
  output logic        CE,
  output logic        OE,
  output logic        WE,
  output logic        UB,
  output logic        LB,
  input  logic [15:0] Data
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic        owner;
  logic        owner_nxt;
  logic [19:0] addr_nxt;
  logic [15:0] rdata_nxt;
  logic [1:0]  gnt_nxt;
  logic [1:0]  rvalid_nxt;
  logic        capture;
  logic        accept;
  logic        winner;

`ifdef SRAM_ARB_RR_EN
  // Port that wins the next tie; always the one not granted most recently.
  logic rr_ptr;
  logic rr_ptr_nxt;

  always_comb begin
    winner     = (req == 2'b11) ? rr_ptr : ~req[0];
    rr_ptr_nxt = accept ? ~winner : rr_ptr;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) rr_ptr <= 1'b0;
    else       rr_ptr <= rr_ptr_nxt;
  end
`else
  // Port 1 can only win when port 0 is not requesting.
  always_comb begin
    winner = ~req[0];
  end
`endif

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    owner_nxt  = owner;
    addr_nxt   = ADDR;
    rdata_nxt  = rdata;
    gnt_nxt    = '0;
    rvalid_nxt = '0;

    capture = (state == ACCESS) && (cnt == '0);
    // req is only looked at when the port is free: in IDLE or at the capture edge.
    accept  = (req != '0) && ((state == IDLE) || capture);

    if ((state == ACCESS) && (cnt != '0)) begin
      cnt_nxt = cnt - 4'd1;
    end

    if (capture) begin
      rdata_nxt         = Data;
      rvalid_nxt[owner] = 1'b1;
      state_nxt         = IDLE;
    end

    // A grant at the capture edge overrides the return to IDLE.
    if (accept) begin
      state_nxt       = ACCESS;
      cnt_nxt         = CNT_LOAD;
      owner_nxt       = winner;
      addr_nxt        = winner ? addr1 : addr0;
      gnt_nxt[winner] = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= IDLE;
      cnt    <= '0;
      owner  <= 1'b0;
      ADDR   <= '0;
      rdata  <= '0;
      gnt    <= '0;
      rvalid <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      owner  <= owner_nxt;
      ADDR   <= addr_nxt;
      rdata  <= rdata_nxt;
      gnt    <= gnt_nxt;
      rvalid <= rvalid_nxt;
    end
  end

  assign busy = (state == ACCESS);
  assign CE   = ~busy;
  assign OE   = ~busy;
  assign WE   = 1'b1;
  assign UB   = 1'b0;
  assign LB   = 1'b0;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Testbench for sram_read_arbiter: directed scenarios plus a randomized
// requester phase, all checked cycle by cycle against a transaction-level
// model that schedules each access by absolute edge number. A second
// instance with WAIT_CYCLES=15 covers the long-wait sampling point.
module tb_sram_read_arbiter;

  localparam int unsigned W = 2;

  logic        CLK;
  logic        RESET;
  logic [1:0]  req;
  logic [19:0] addr0;
  logic [19:0] addr1;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [15:0] rdata;
  logic        busy;
  logic [19:0] ADDR;
  logic        CE, OE, WE, UB, LB;
  logic [15:0] Data;

  logic [1:0]  req_l;
  logic [19:0] addr0_l;
  logic [19:0] addr1_l;
  logic [1:0]  gnt_l;
  logic [1:0]  rvalid_l;
  logic [15:0] rdata_l;
  logic        busy_l;
  logic [19:0] ADDR_l;
  logic        CE_l, OE_l, WE_l, UB_l, LB_l;
  logic [15:0] Data_l;

  logic [15:0] mem [256];
  assign Data = mem[ADDR[7:0]];

  sram_read_arbiter #(.WAIT_CYCLES(W)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .addr0(addr0), .addr1(addr1),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy), .ADDR(ADDR),
    .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB), .Data(Data)
  );

  sram_read_arbiter #(.WAIT_CYCLES(15)) dut_long (
    .CLK(CLK), .RESET(RESET), .req(req_l), .addr0(addr0_l), .addr1(addr1_l),
    .gnt(gnt_l), .rvalid(rvalid_l), .rdata(rdata_l), .busy(busy_l), .ADDR(ADDR_l),
    .CE(CE_l), .OE(OE_l), .WE(WE_l), .UB(UB_l), .LB(LB_l), .Data(Data_l)
  );

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned ecnt;
  bit          m_busy;
  int unsigned m_cap;      // edge number at which the current access captures
  bit          m_owner;
  bit          m_last;     // port granted most recently
  logic [19:0] m_addr;
  logic [15:0] m_rdata;
  logic [1:0]  e_gnt;
  logic [1:0]  e_rvalid;

  task automatic model_reset();
    m_busy   = 1'b0;
    m_addr   = '0;
    m_rdata  = '0;
    e_gnt    = '0;
    e_rvalid = '0;
    m_last   = 1'b1;
  endtask

  function automatic bit pick(input logic [1:0] r);
    if (r == 2'b11) begin
`ifdef SRAM_ARB_RR_EN
      return ~m_last;
`else
      return 1'b0;
`endif
    end
    return r[1];
  endfunction

  task automatic model_edge();
    bit free;
    bit w;
    ecnt++;
    e_gnt    = '0;
    e_rvalid = '0;
    free     = !m_busy;
    if (m_busy && ecnt == m_cap) begin
      m_rdata           = mem[m_addr[7:0]];
      e_rvalid[m_owner] = 1'b1;
      m_busy            = 1'b0;
      free              = 1'b1;
    end
    if (free && req != 2'b00) begin
      w          = pick(req);
      m_owner    = w;
      m_last     = w;
      m_addr     = w ? addr1 : addr0;
      m_cap      = ecnt + W;
      m_busy     = 1'b1;
      e_gnt[w]   = 1'b1;
    end
  endtask

  task automatic check_main();
    check("gnt",    20'(gnt),    20'(e_gnt));
    check("rvalid", 20'(rvalid), 20'(e_rvalid));
    check("rdata",  20'(rdata),  20'(m_rdata));
    check("ADDR",   ADDR,        m_addr);
    check("busy",   20'(busy),   20'(m_busy));
    check("CE",     20'(CE),     20'(!m_busy));
    check("OE",     20'(OE),     20'(!m_busy));
    check("WE",     20'(WE),     20'h1);
    check("UB",     20'(UB),     20'h0);
    check("LB",     20'(LB),     20'h0);
  endtask

  task automatic step();
    @(posedge CLK);
    if (RESET) model_reset();
    else       model_edge();
    #1;
    check_main();
  endtask

  // ---------------- stimulus ----------------
  int          gq[$];
  int          exp_order[4];
  logic [15:0] words[$];
  int          wcyc[$];
  bit   [1:0]  pend;
  int          n;

  initial begin
    RESET   = 1'b1;
    req     = '0;
    addr0   = '0;
    addr1   = '0;
    req_l   = '0;
    addr0_l = '0;
    addr1_l = '0;
    Data_l  = '0;
    ecnt    = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    model_reset();

    // Reset values, checked before any clock edge.
    #1;
    check_main();
    check("rst_CE_long", 20'(CE_l), 20'h1);
    step();
    #5 RESET = 1'b0;

    // Contention from a fresh reset: four grants with req=11 held.
`ifdef SRAM_ARB_RR_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    req   = 2'b11;
    addr0 = 20'h00010;
    addr1 = 20'h00020;
    for (int c = 0; c < 7; c++) begin
      step();
      if (gnt[0]) gq.push_back(0);
      if (gnt[1]) gq.push_back(1);
    end
    check("order_len", 20'(gq.size()), 20'd4);
    for (int i = 0; i < 4 && i < gq.size(); i++) check("order", 20'(gq[i]), 20'(exp_order[i]));
    req = 2'b10;
    step();
    step();
    check("late_gnt1", 20'(gnt), 20'h2);
    req = 2'b00;
    for (int c = 0; c < 3; c++) step();

    // Single read.
    mem[8'h88] = 16'hBEEF;
    req   = 2'b01;
    addr0 = 20'h00188;
    step();
    check("single_gnt", 20'(gnt), 20'h1);
    check("single_CE0", 20'(CE), 20'h0);
    req = 2'b00;
    step();
    check("single_OE1", 20'(OE), 20'h0);
    step();
    check("single_rvalid", 20'(rvalid), 20'h1);
    check("single_rdata", 20'(rdata), 20'h0BEEF);
    check("single_CE_hi", 20'(CE), 20'h1);
    step();

    // Back-to-back reads from port 1.
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    mem[2] = 16'h3333;
    req   = 2'b10;
    addr1 = 20'h00000;
    n     = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (rvalid[1]) begin
        words.push_back(rdata);
        wcyc.push_back(c);
      end
      if (e_gnt[1]) begin
        n++;
        if (n < 3) addr1 = 20'(n);
        else       req = 2'b00;
      end
    end
    check("b2b_count", 20'(words.size()), 20'd3);
    if (words.size() == 3) begin
      check("b2b_w0", 20'(words[0]), 20'h01111);
      check("b2b_w1", 20'(words[1]), 20'h02222);
      check("b2b_w2", 20'(words[2]), 20'h03333);
      check("b2b_gap1", 20'(wcyc[1] - wcyc[0]), 20'd2);
      check("b2b_gap2", 20'(wcyc[2] - wcyc[1]), 20'd2);
    end

    // Reset one cycle after gnt.
    req   = 2'b01;
    addr0 = 20'h00005;
    step();
    req = 2'b00;
    step();
    #5 RESET = 1'b1;
    #1;
    check("mid_rst_busy",  20'(busy),   20'h0);
    check("mid_rst_ADDR",  ADDR,        20'h0);
    check("mid_rst_rdata", 20'(rdata),  20'h0);
    check("mid_rst_CE",    20'(CE),     20'h1);
    check("mid_rst_OE",    20'(OE),     20'h1);
    check("mid_rst_gnt",   20'(gnt),    20'h0);
    model_reset();
    step();
    #5 RESET = 1'b0;
    for (int c = 0; c < 4; c++) step();
    req   = 2'b01;
    addr0 = 20'h00077;
    step();
    req = 2'b00;
    step();
    step();
    check("post_rst_rvalid", 20'(rvalid), 20'h1);
    check("post_rst_rdata", 20'(rdata), 20'(mem[8'h77]));

    // Randomized requesters following the hold-until-gnt protocol.
    pend = '0;
    for (int c = 0; c < 300; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (e_gnt[p] || !pend[p]) begin
          pend[p] = ($urandom_range(0, 2) != 0);
          if (p == 0) addr0 = 20'($urandom);
          else        addr1 = 20'($urandom);
        end
      end
      req = pend;
      step();
    end
    req = 2'b00;
    for (int c = 0; c < 4; c++) step();

    // Long wait: Data changes every cycle; only the value at edge E+15 is kept.
    req_l   = 2'b01;
    addr0_l = 20'h0ABCD;
    Data_l  = 16'h1000;
    @(posedge CLK); #1;
    check("long_gnt", 20'(gnt_l), 20'h1);
    check("long_busy", 20'(busy_l), 20'h1);
    req_l = 2'b00;
    for (int k = 1; k <= 15; k++) begin
      Data_l = 16'h1000 + 16'(k);
      @(posedge CLK); #1;
      if (k < 15) begin
        check("long_no_rvalid", 20'(rvalid_l), 20'h0);
        check("long_CE_low", 20'(CE_l), 20'h0);
      end else begin
        check("long_rvalid", 20'(rvalid_l), 20'h1);
        check("long_rdata", 20'(rdata_l), 20'h0100F);
        check("long_busy_end", 20'(busy_l), 20'h0);
        check("long_ADDR", ADDR_l, 20'h0ABCD);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
